// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Write-back arbiter in front of the register file's single write port. It
// merges the in-order pipeline (ALU) result stream with results returning from
// the long-latency unit (mul/div, loads) into one registered write. It also
// keeps a per-register busy scoreboard for long-latency destinations, which
// the hazard logic uses to stall dependent instructions.
//
// A long-latency result is parked in a one-entry hold register. The ALU wins
// the port while a result is held. A starvation counter bounds that wait: once
// the hold has lost STARVE_MAX times in a row, a one-cycle stall forces the
// pipeline to idle so the held result can drain.
//
// Parameters
//   XLEN        data width
//   STARVE_MAX  ALU-granted cycles a held result may wait before a forced
//               stall (1..15)
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   alu_valid/rd/data        pipeline result (never back-pressured except by
//                            stall)
//   lu_valid/rd/data         long-latency result offer
//   lu_ready                 long-latency result accepted this cycle (comb)
//   issue_valid/issue_rd     long-latency op issued; marks rd busy
//   we, rd, wd               registered register-file write
//   busy                     registered scoreboard, bit n = x_n pending
//   stall                    registered; upstream must hold alu_valid low
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            we,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd,
  output logic [31:0]     busy,
  output logic            stall
);

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  // Hold register for one long-latency result.
  logic            hold_v_q,    hold_v_d;
  logic [4:0]      hold_rd_q,   hold_rd_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;

  // Starvation counter and registered outputs.
  logic [3:0]      starve_q,    starve_d;
  logic            stall_q,     stall_d;
  logic            we_q,        we_d;
  logic [4:0]      rd_q,        rd_d;
  logic [XLEN-1:0] wd_q,        wd_d;
  logic [31:0]     busy_q,      busy_d;

  // The write currently on we/rd/wd came from the hold register, so its
  // commit at the next edge retires the scoreboard entry.
  logic            wb_hold_q,   wb_hold_d;

  logic grant_alu;
  logic grant_hold;
  logic lu_accept;

  // During a stall the ALU is locked out, so the hold always wins; otherwise
  // the hold only gets the port on cycles the pipeline leaves empty.
  assign grant_hold = hold_v_q && (stall_q || !alu_valid);
  assign grant_alu  = alu_valid && !stall_q;

  // Draining the hold frees the entry in the same cycle, which is what lets
  // the long-latency unit sustain one result per cycle.
  assign lu_ready  = !hold_v_q || grant_hold;
  assign lu_accept = lu_valid && lu_ready;

  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    we_d      = 1'b0;
    rd_d      = rd_q;
    wd_d      = wd_q;
    wb_hold_d = 1'b0;
    if (grant_alu) begin
      we_d = (alu_rd != 5'd0);
      rd_d = alu_rd;
      wd_d = alu_data;
    end else if (grant_hold) begin
      // A write to x0 is suppressed but still consumes the held entry.
      we_d      = (hold_rd_q != 5'd0);
      rd_d      = hold_rd_q;
      wd_d      = hold_data_q;
      wb_hold_d = 1'b1;
    end
  end

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (lu_accept) begin
      hold_v_d    = 1'b1;
      hold_rd_d   = lu_rd;
      hold_data_d = lu_data;
    end else if (grant_hold) begin
      hold_v_d = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!hold_v_q || grant_hold) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
    // The hold losing on its last allowed cycle forces one stall cycle; the
    // stall itself grants the hold, so it can never persist.
    stall_d = hold_v_q && !grant_hold && (starve_q == STARVE_LAST);
  end

  always_comb begin
    busy_d = busy_q;
    if (we_q && wb_hold_q) begin
      busy_d[rd_q] = 1'b0;
    end
    // Applied after the clear so a same-edge re-issue keeps the bit set.
    if (issue_valid) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_rd_q   <= 5'd0;
      hold_data_q <= '0;
      starve_q    <= 4'd0;
      stall_q     <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 5'd0;
      wd_q        <= '0;
      busy_q      <= 32'd0;
      wb_hold_q   <= 1'b0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
      busy_q      <= busy_d;
      wb_hold_q   <= wb_hold_d;
    end
  end

  assign we    = we_q;
  assign rd    = rd_q;
  assign wd    = wd_q;
  assign busy  = busy_q;
  assign stall = stall_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly upstream of the register file's single write port. Merges the in-order ALU/pipeline result stream with results from the long-latency unit (mul/div, loads) into one registered write (`we`, `rd`, `wd`). Keeps a per-register busy scoreboard for long-latency destinations, which the hazard logic uses to stall dependent instructions. Holds one long-latency result and bounds its wait with a starvation counter.

## Interface
- `XLEN`, 32, data width
- `STARVE_MAX`, 4, cycles a held long-latency result may wait before forcing a pipeline stall (1..15)

- `clk` input 1: rising-edge clock
- `rst` input 1: asynchronous, active-high reset
- `alu_valid` input 1: pipeline result present this cycle; never back-pressured except via `stall`
- `alu_rd` input 5: pipeline destination
- `alu_data` input XLEN: pipeline result
- `lu_valid` input 1: long-latency result offered
- `lu_ready` output 1: arbiter accepts the long-latency result this cycle (combinational)
- `lu_rd` input 5: long-latency destination
- `lu_data` input XLEN: long-latency result
- `issue_valid` input 1: a long-latency op is issued this cycle
- `issue_rd` input 5: its destination
- `we` output 1: register-file write enable (registered)
- `rd` output 5: register-file write address (registered)
- `wd` output XLEN: register-file write data (registered)
- `busy` output 32: scoreboard; bit n set means x_n awaits a long-latency result (registered)
- `stall` output 1: upstream must hold `alu_valid` low this cycle (registered)

## Operation
- Hold register: one entry (`hold_v`, `hold_rd`, `hold_data`).
- `lu_ready = !hold_v || grant_hold`.
- A long-latency result is accepted when `lu_valid && lu_ready`; it loads the hold register.
- Grant priority:
  - If `stall = 1`: grant hold.
  - Else if `alu_valid`: grant ALU.
  - Else if `hold_v`: grant hold.
  - Else: idle.
- On a grant, the next edge loads `rd`/`wd` from the granted source.
  - `we = 1` unless the granted rd is 0. In that case `we = 0`, but the entry is still consumed.
  - Idle: `we = 0`. `rd` and `wd` hold their last values.
- Hold drain and new accept in the same cycle: the hold register takes the new result and `hold_v` stays 1.
- Starvation counter (4 bits):
  - Clears when `hold_v = 0` or the hold is granted.
  - Otherwise increments while hold waits because an ALU result was granted.
  - When it reaches `STARVE_MAX - 1` and the hold loses that cycle, `stall` is set for exactly one cycle.
- `alu_valid = 1` while `stall = 1` is a protocol violation. That ALU result is dropped, and the bench flags it as an assertion.
- Scoreboard:
  - `issue_valid` with `issue_rd != 0` sets `busy[issue_rd]`.
  - A hold-sourced write clears `busy[rd]` at the edge after `we` is presented, i.e. when the register file commits.
  - Same-edge set and clear of the same bit: set wins.
  - `busy[0]` is always 0.
- ALU writes never touch `busy`.

## Timing
- Reset (async, immediate): `we = 0`, `rd = 0`, `wd = 0`, `busy = 0`, `stall = 0`, `hold_v = 0`, counter = 0. `lu_ready` is 1 during reset.
- Latency:
  - ALU input at cycle N gives `we`/`rd`/`wd` in cycle N+1, and the register-file commit at the end of N+1.
  - Long-latency result accepted at N with no ALU traffic gives `we` at N+2 (N+1 grant, N+2 outputs).
- `busy` bit clears visibly in cycle N+3 for that case (write committed at end of N+2).
- Sustained long-latency throughput with no ALU traffic: one result per cycle, because of the same-cycle drain-and-accept rule.
- Worst-case wait of a held result: `STARVE_MAX` ALU-granted cycles, then the forced stall cycle.
- Reset asserted mid-operation discards the held result and clears the scoreboard. Issued but unreturned ops must be flushed by the long-latency unit under the same reset.

## Test plan
- Reset then idle:
  - Stimulus: `rst` pulse mid-cycle.
  - Response: outputs zero immediately; `lu_ready = 1`; `we` stays 0 with no inputs.
- ALU stream:
  - Stimulus: `alu_valid` for rd = 5, 6, 0 with data 0xA, 0xB, 0xC on consecutive cycles.
  - Response: `we` = 1, 1, 0 one cycle later; `rd`/`wd` match; `busy` unchanged.
- Long-latency round trip:
  - Stimulus: issue rd = 7; after 3 cycles, `lu_valid` rd = 7, data 0x1234, with no ALU traffic.
  - Response: `busy[7]` = 1 the cycle after issue; `we` with rd = 7, `wd` = 0x1234 two cycles after accept; `busy[7]` = 0 the cycle after that.
- Starvation:
  - Stimulus: `STARVE_MAX = 4`; hold valid; `alu_valid` continuous.
  - Response: ALU granted for 4 cycles; `stall = 1` for one cycle; hold written with `alu_valid` dropped by the bench; `stall` back to 0.
- Back-pressure and drain-accept:
  - Stimulus: hold full; `alu_valid = 1`; new `lu_valid`.
  - Response: `lu_ready = 0`.
  - Stimulus: `alu_valid = 0` in the next cycle.
  - Response: `lu_ready = 1`, and the old and new results are written on consecutive cycles.
- Scoreboard collision:
  - Stimulus: hold write for rd = 9 commits in the same edge as issue rd = 9.
  - Response: `busy[9]` remains 1.
  - Stimulus: issue rd = 0.
  - Response: `busy[0]` stays 0.
